// File: rtl/gpio_reg_bank.sv
// gpio_reg_bank
//   Decodes the PS GPIO write bus into a bank of NUM_REGS configuration
//   registers, each REG_W bits wide. Registers wider than one data byte are
//   assembled MSB-first over consecutive writes to the same address.
//   Addresses flagged in TRIG_MASK are trigger registers: a write to one
//   produces a single-cycle pulse and stores nothing.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   gpio_in      in   raw PS GPIO bus {strobe, data, addr}, asynchronous to clk
//   reg_out      out  register i at bits [i*REG_W +: REG_W]
//   reg_wr_pulse out  one-cycle pulse when register i commits
//   trig_pulse   out  one-cycle pulse on a write to trigger register i
//   err_addr     out  sticky flag: a write hit an address outside the bank
//   wr_count     out  number of detected write events, wraps at 2^16
module gpio_reg_bank #(
    parameter int                  GPIO_W_CLK_BIT = 24,
    parameter int                  ADDR_W         = 16,
    parameter int                  DATA_W         = 8,
    parameter int                  NUM_REGS       = 16,
    parameter int                  REG_W          = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR      = ADDR_W'(16'h0000),
    parameter logic [NUM_REGS-1:0] TRIG_MASK      = NUM_REGS'(32'h0000_0007)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [GPIO_W_CLK_BIT:0]   gpio_in,
    output logic [NUM_REGS*REG_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]       reg_wr_pulse,
    output logic [NUM_REGS-1:0]       trig_pulse,
    output logic                      err_addr,
    output logic [15:0]               wr_count
);

    localparam int BYTES = REG_W / DATA_W;
    localparam int CNT_W = $clog2(BYTES + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_COMMIT   = 2'd2
    } state_t;

    // Synchroniser and edge detection
    logic [GPIO_W_CLK_BIT:0] s1_r;
    logic [GPIO_W_CLK_BIT:0] s2_r;
    logic                    s3_r;
    logic [1:0]              fill_r;
    logic                    armed_r;

    // Assembly state
    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   byte_cnt_r;
    logic [CNT_W-1:0]   byte_cnt_nxt_s;
    logic [REG_W-1:0]   stage_r;
    logic [REG_W-1:0]   stage_nxt_s;
    logic [IDX_W-1:0]   stage_idx_r;
    logic [IDX_W-1:0]   stage_idx_nxt_s;
    logic [NUM_REGS-1:0] trig_nxt_s;
    logic               commit_s;
    logic               err_nxt_s;

    // Decoded fields of the synchronised bus
    logic               strobe_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [DATA_W-1:0]  data_s;
    logic [ADDR_W:0]    offset_s;
    logic               in_range_s;
    logic [IDX_W-1:0]   idx_s;
    logic               is_trig_s;
    logic               event_s;

    assign strobe_s   = s2_r[GPIO_W_CLK_BIT];
    assign addr_s     = s2_r[ADDR_W-1:0];
    assign data_s     = s2_r[ADDR_W+DATA_W-1:ADDR_W];
    // One extra bit so the subtraction cannot wrap back into range.
    assign offset_s   = {1'b0, addr_s} - {1'b0, BASE_ADDR};
    assign in_range_s = (addr_s >= BASE_ADDR) && (offset_s < (ADDR_W+1)'(NUM_REGS));
    assign idx_s      = offset_s[IDX_W-1:0];
    assign is_trig_s  = TRIG_MASK[idx_s];
    assign event_s    = strobe_s & ~s3_r & armed_r;

    // Two-flop synchroniser, previous-strobe flop and arming logic.
    // fill_r marks when s2 holds a real sample of gpio_in rather than its
    // reset value; without it a strobe held high across reset release would
    // look like a low-then-high transition and fire a spurious write.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r    <= '0;
            s2_r    <= '0;
            s3_r    <= 1'b0;
            fill_r  <= 2'b00;
            armed_r <= 1'b0;
        end else begin
            s1_r    <= gpio_in;
            s2_r    <= s1_r;
            s3_r    <= strobe_s;
            fill_r  <= {fill_r[0], 1'b1};
            armed_r <= armed_r | (fill_r[1] & ~strobe_s);
        end
    end

    // Next-state logic: event decode, byte assembly and commit sequencing.
    always_comb begin
        state_nxt_s     = state_r;
        byte_cnt_nxt_s  = byte_cnt_r;
        stage_nxt_s     = stage_r;
        stage_idx_nxt_s = stage_idx_r;
        trig_nxt_s      = '0;
        commit_s        = 1'b0;
        err_nxt_s       = err_addr;
        case (state_r)
            ST_IDLE, ST_ASSEMBLE: begin
                if (event_s) begin
                    if (!in_range_s) begin
                        err_nxt_s = 1'b1;
                    end else if (is_trig_s) begin
                        trig_nxt_s[idx_s] = 1'b1;
                        byte_cnt_nxt_s    = '0;
                        state_nxt_s       = ST_IDLE;
                    end else if ((byte_cnt_r == '0) || (stage_idx_r != idx_s)) begin
                        // First byte, or a different register: drop any partial word.
                        stage_nxt_s     = REG_W'(data_s);
                        stage_idx_nxt_s = idx_s;
                        byte_cnt_nxt_s  = CNT_W'(1);
                        state_nxt_s     = (byte_cnt_nxt_s == CNT_W'(BYTES)) ? ST_COMMIT : ST_ASSEMBLE;
                    end else begin
                        stage_nxt_s    = (stage_r << DATA_W) | REG_W'(data_s);
                        byte_cnt_nxt_s = byte_cnt_r + CNT_W'(1);
                        state_nxt_s    = (byte_cnt_nxt_s == CNT_W'(BYTES)) ? ST_COMMIT : ST_ASSEMBLE;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_COMMIT: begin
                // Events are spaced so that none can land in this cycle.
                commit_s       = 1'b1;
                byte_cnt_nxt_s = '0;
                state_nxt_s    = ST_IDLE;
            end
            default: begin
                byte_cnt_nxt_s = '0;
                state_nxt_s    = ST_IDLE;
            end
        endcase
    end

    // Assembly state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            byte_cnt_r  <= '0;
            stage_r     <= '0;
            stage_idx_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            byte_cnt_r  <= byte_cnt_nxt_s;
            stage_r     <= stage_nxt_s;
            stage_idx_r <= stage_idx_nxt_s;
        end
    end

    // Registered outputs: register bank, pulses, error flag and event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_out      <= '0;
            reg_wr_pulse <= '0;
            trig_pulse   <= '0;
            err_addr     <= 1'b0;
            wr_count     <= 16'd0;
        end else begin
            trig_pulse   <= trig_nxt_s;
            err_addr     <= err_nxt_s;
            wr_count     <= wr_count + (event_s ? 16'd1 : 16'd0);
            reg_wr_pulse <= '0;
            if (commit_s) begin
                reg_out[int'(stage_idx_r)*REG_W +: REG_W] <= stage_r;
                reg_wr_pulse[stage_idx_r]                 <= 1'b1;
            end else begin
                reg_out <= reg_out;
            end
        end
    end

endmodule

// File: tb/tb_gpio_reg_bank.sv
// Directed testbench for gpio_reg_bank. A write-level model predicts, for
// every write issued, which cycle the counter/error/trigger effects and the
// commit must appear on; one compare process checks all outputs every cycle.
module tb_gpio_reg_bank;

    localparam int NR = 16;
    localparam int RW = 32;
    localparam logic [15:0] TRIG = 16'h0007;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [24:0]       gpio_in = 25'd0;
    logic [NR*RW-1:0]  reg_out;
    logic [NR-1:0]     reg_wr_pulse;
    logic [NR-1:0]     trig_pulse;
    logic              err_addr;
    logic [15:0]       wr_count;

    gpio_reg_bank dut (
        .clk          (clk),
        .rst          (rst),
        .gpio_in      (gpio_in),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse),
        .trig_pulse   (trig_pulse),
        .err_addr     (err_addr),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    logic [RW-1:0] exp_reg [NR];
    logic          exp_err;
    logic [15:0]   exp_count;
    int            ev_cyc = -1;
    bit            ev_oor;
    int            trig_cyc = -1;
    int            trig_idx;
    int            commit_cyc = -1;
    int            commit_idx;
    logic [RW-1:0] commit_val;
    int            stg_idx;
    int            stg_cnt;
    logic [RW-1:0] stg_val;
    bit            loose = 1'b0;
    int            loose_trigs;
    bit            chk_on = 1'b0;

    int checks = 0;
    int errors = 0;

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin : cmp_proc
        logic [NR*RW-1:0] er;
        logic [NR-1:0]    et;
        logic [NR-1:0]    ew;
        #1;
        if (chk_on) begin
            if (cyc == ev_cyc) begin
                exp_count = exp_count + 16'd1;
                if (ev_oor) exp_err = 1'b1;
            end
            if (cyc == commit_cyc) exp_reg[commit_idx] = commit_val;
            et = '0;
            if (cyc == trig_cyc) et[trig_idx] = 1'b1;
            ew = '0;
            if (cyc == commit_cyc) ew[commit_idx] = 1'b1;
            for (int i = 0; i < NR; i++) er[i*RW +: RW] = exp_reg[i];
            checks++;
            if (loose) begin
                if (trig_pulse != '0) loose_trigs++;
                if (reg_out !== er || reg_wr_pulse !== ew || err_addr !== exp_err) begin
                    errors++;
                    $display("FAIL cycle_cmp_short cyc=%0d reg_out=%h want %h wr_pulse=%h want %h err=%b want %b",
                             cyc, reg_out, er, reg_wr_pulse, ew, err_addr, exp_err);
                end
            end else if (reg_out !== er || reg_wr_pulse !== ew || trig_pulse !== et ||
                         err_addr !== exp_err || wr_count !== exp_count) begin
                errors++;
                $display("FAIL cycle_cmp cyc=%0d reg_out=%h want %h wr_pulse=%h want %h trig=%h want %h err=%b want %b count=%0d want %0d",
                         cyc, reg_out, er, reg_wr_pulse, ew, trig_pulse, et, err_addr, exp_err, wr_count, exp_count);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, want);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) exp_reg[i] = '0;
        exp_err    = 1'b0;
        exp_count  = 16'd0;
        ev_cyc     = -1;
        trig_cyc   = -1;
        commit_cyc = -1;
        stg_cnt    = 0;
        stg_idx    = 0;
        stg_val    = '0;
    endtask

    // Record the effects of a write whose strobe is first sampled at edge t.
    task automatic model_event(input int t, input logic [15:0] a, input logic [7:0] d);
        ev_cyc = t + 2;
        ev_oor = (a >= 16'(NR));
        if (!ev_oor) begin
            if (TRIG[a[3:0]]) begin
                trig_cyc = t + 2;
                trig_idx = int'(a);
                stg_cnt  = 0;
            end else begin
                if (stg_cnt == 0 || stg_idx != int'(a)) begin
                    stg_val = RW'(d);
                    stg_cnt = 1;
                    stg_idx = int'(a);
                end else begin
                    stg_val = stg_val * 256 + RW'(d);
                    stg_cnt = stg_cnt + 1;
                end
                if (stg_cnt == RW / 8) begin
                    commit_cyc = t + 3;
                    commit_idx = stg_idx;
                    commit_val = stg_val;
                    stg_cnt    = 0;
                end
            end
        end
    endtask

    // One GPIO write: fields set up 3 cycles ahead, strobe high 3, low 4.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        gpio_in = {1'b0, d, a};
        tick(3);
        gpio_in[24] = 1'b1;
        model_event(cyc + 1, a, d);
        tick(3);
        gpio_in[24] = 1'b0;
        tick(4);
    endtask

    task automatic do_reset(input bit strobe_high);
        rst = 1'b1;
        gpio_in[24] = strobe_high;
        model_clear();
        tick(2);
        rst = 1'b0;
    endtask

    initial begin : stim
        logic [15:0] cnt0;
        logic [15:0] d;
        model_clear();
        tick(1);
        chk_on = 1'b1;
        do_reset(1'b0);
        tick(4);
        chk("reset_count", 64'(wr_count), 64'd0);
        chk("reset_err", 64'(err_addr), 64'd0);
        chk("reset_reg5", 64'(reg_out[5*RW +: RW]), 64'd0);

        // Four-byte assembly, MSB first
        wr(16'h0005, 8'hDE); wr(16'h0005, 8'hAD); wr(16'h0005, 8'hBE); wr(16'h0005, 8'hEF);
        chk("reg5_value", 64'(reg_out[5*RW +: RW]), 64'hDEAD_BEEF);
        chk("count_after_4", 64'(wr_count), 64'd4);

        // Trigger register
        wr(16'h0001, 8'h01);
        chk("count_after_trig", 64'(wr_count), 64'd5);
        chk("reg1_untouched", 64'(reg_out[1*RW +: RW]), 64'd0);

        // Out-of-range write mid-assembly leaves staging intact
        wr(16'h0009, 8'h12); wr(16'h0009, 8'h34);
        wr(16'h0010, 8'h55);
        wr(16'h0009, 8'h56); wr(16'h0009, 8'h78);
        chk("err_set", 64'(err_addr), 64'd1);
        chk("reg9_value", 64'(reg_out[9*RW +: RW]), 64'h1234_5678);

        // Switching register mid-assembly discards the partial word
        wr(16'h0006, 8'h11); wr(16'h0006, 8'h22);
        wr(16'h0007, 8'hAA); wr(16'h0007, 8'hBB); wr(16'h0007, 8'hCC); wr(16'h0007, 8'hDD);
        chk("reg6_zero", 64'(reg_out[6*RW +: RW]), 64'd0);
        chk("reg7_value", 64'(reg_out[7*RW +: RW]), 64'hAABB_CCDD);
        chk("err_sticky", 64'(err_addr), 64'd1);

        // One-cycle strobe: at most one event, never a duplicate
        loose = 1'b1;
        loose_trigs = 0;
        cnt0 = wr_count;
        gpio_in = {1'b0, 8'h00, 16'h0002};
        tick(3);
        gpio_in[24] = 1'b1;
        tick(1);
        gpio_in[24] = 1'b0;
        tick(6);
        d = wr_count - cnt0;
        chk("short_strobe_once", 64'((d <= 16'd1) && (int'(d) == loose_trigs)), 64'd1);
        exp_count = exp_count + d;
        loose = 1'b0;
        tick(1);
        wr(16'h0002, 8'h00);
        chk("count_after_short", 64'(wr_count), 64'(cnt0 + d + 16'd1));

        // Reset mid-assembly, released with the strobe still high
        wr(16'h0008, 8'h12); wr(16'h0008, 8'h34);
        gpio_in = {1'b0, 8'h99, 16'h0008};
        do_reset(1'b1);
        tick(8);
        chk("no_event_at_release", 64'(wr_count), 64'd0);
        gpio_in[24] = 1'b0;
        tick(4);
        wr(16'h0008, 8'h01); wr(16'h0008, 8'h02); wr(16'h0008, 8'h03); wr(16'h0008, 8'h04);
        chk("reg8_fresh", 64'(reg_out[8*RW +: RW]), 64'h0102_0304);
        chk("count_fresh", 64'(wr_count), 64'd4);
        chk("err_cleared", 64'(err_addr), 64'd0);
        chk("reg5_cleared", 64'(reg_out[5*RW +: RW]), 64'd0);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_reg_bank.md
# gpio_reg_bank

Parametrised successor to the fixed GPIO config-register map. It decodes the PS GPIO write bus (strobe bit, address field, data byte) into a bank of NUM_REGS configuration registers that are REG_W bits wide. Registers wider than one GPIO byte are assembled MSB-first over consecutive writes. Addresses flagged in TRIG_MASK act as trigger registers (run, delay-cal, halt and similar) and emit single-cycle pulses instead of storing a value. The block sits between the PS GPIO and every config consumer (DAC drivers, output scalers, executor).

## Interface
- GPIO_W_CLK_BIT, 24, bit index of the write strobe in gpio_in
- ADDR_W, 16, address field width, at gpio_in[ADDR_W-1:0]
- DATA_W, 8, data field width, at gpio_in[ADDR_W+DATA_W-1:ADDR_W]
- NUM_REGS, 16, registers in the bank (≥1)
- REG_W, 32, register width; integer multiple of DATA_W; BYTES = REG_W/DATA_W
- BASE_ADDR, 16'h0000, address of register index 0
- TRIG_MASK, 'h7, NUM_REGS bits; bit i=1 makes register i a trigger register
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- gpio_in, in, GPIO_W_CLK_BIT+1, raw PS GPIO bus, asynchronous to clk
- reg_out, out, NUM_REGS*REG_W, register i occupies bits [i*REG_W +: REG_W]
- reg_wr_pulse, out, NUM_REGS, one-cycle pulse when register i commits
- trig_pulse, out, NUM_REGS, one-cycle pulse on a write to trigger register i
- err_addr, out, 1, sticky flag for an out-of-range write address
- wr_count, out, 16, count of detected write events; wraps at 2^16

## Operation
- The whole gpio_in bus passes through a 2-flop synchroniser (s1, s2). s3 holds the previous value of the s2 strobe bit.
- A write event is s2 strobe=1, s3=0 and armed=1. Address and data are taken from s2 in the same cycle.
- armed resets to 0 and is set on the first cycle with s2 strobe=0. A strobe already high at reset release therefore produces no event.
- idx = addr − BASE_ADDR. The address is in range when BASE_ADDR ≤ addr < BASE_ADDR+NUM_REGS.
- Every event increments wr_count.
- Out-of-range event: set err_addr. Staging is unchanged.
- Trigger register, in range: pulse trig_pulse[idx] and clear byte_cnt. reg_out is unchanged.
- Data register, in range, with byte_cnt==0 or stage_idx≠idx: stage←zero-extended data, stage_idx←idx, byte_cnt←1.
- Data register, in range, otherwise: stage←{stage[REG_W-DATA_W-1:0], data}, byte_cnt++.
- When byte_cnt reaches BYTES: commit on the next cycle. reg_out[stage_idx]←stage, reg_wr_pulse[stage_idx]=1, byte_cnt←0.
- Commit states: IDLE (byte_cnt=0), ASSEMBLE (0<byte_cnt<BYTES), COMMIT (byte_cnt=BYTES, lasts one cycle, returns to IDLE).
- BYTES=1: every data write commits.
- A write to a different data register mid-assembly discards the partial word and restarts on the new index.
- Reset values are all 0: reg_out, pulses, err_addr, wr_count, stage, byte_cnt, s1/s2/s3, armed.
- Reset mid-assembly discards the partial word.

## Timing
- T is the first clk edge that samples gpio_in strobe=1. s2 becomes 1 after T+1.
- The event is processed at edge T+2:
  - trig_pulse is high for cycle T+2..T+3.
  - stage and byte_cnt update after T+2.
- Final byte commit: reg_out and reg_wr_pulse update after T+3; the pulse lasts one cycle.
- Latency from strobe to reg_out is 4 edges; from strobe to trig_pulse it is 3 edges.
- Software keeps address and data stable from 3 cycles before the strobe rises until the strobe falls.
- The strobe high and low phases are each ≥3 clk cycles; shorter phases may be missed.
- The next event is at T+4 at the earliest, so it never coincides with a commit. An event in the COMMIT cycle cannot occur.
- reg_out holds its value until the next commit to the same index.

## Test plan
- Reset, then write 0xDE,0xAD,0xBE,0xEF to addr 0x0005 (REG_W=32) → reg_out[5]=0xDEADBEEF after the 4th write's T+3; reg_wr_pulse[5] is high one cycle; wr_count=4.
- Write 0x01 to addr 0x0001 (trigger) → trig_pulse[1] high exactly one cycle at T+2; reg_out unchanged; no reg_wr_pulse.
- Write 0x11,0x22 to addr 6, then 0xAA,0xBB,0xCC,0xDD to addr 7 → reg_out[6] stays 0; reg_out[7]=0xAABBCCDD.
- Write to addr 0x0010 (NUM_REGS=16) → err_addr=1 and stays 1 through further valid writes until rst; no register changes.
- Assert rst after 2 of 4 bytes; release with the strobe held high; then complete 4 fresh writes → no event at release; reg_out = only the fresh 4-byte value.
- Strobe high for 1 cycle → event may be dropped but must never produce a duplicate write; a 3-cycle strobe is always detected exactly once.
